memory_data: RTL and testbench

- Word-addressed 16-bit data memory for the 16-bit MIPS-style datapath, sitting in the MEM stage.
- Stores register values on a write strobe (Wm) and returns the addressed word on a read strobe (Rm).
- Synchronous write, combinational read, asynchronous active-low clear of the whole array.

---
 rtl/memory_data_pkg.sv | 16 +
 rtl/memory_data.sv | 65 ++++++
 tb/tb_memory_data.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_data_pkg.sv
// Shared constants and word type for the MEM-stage data memory.
package memdata_pkg;

  localparam int unsigned MEMDATA_DATA_W = 16;
  localparam int unsigned MEMDATA_ADDR_W = 16;
  localparam int unsigned MEMDATA_DEPTH  = 64;

  typedef logic [15:0] word_t;

  // Full-width compare so upper address bits never alias into the array.
  function automatic logic in_range(input logic [MEMDATA_ADDR_W-1:0] addr,
                                    input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/memory_data.sv
// Word-addressed data memory: synchronous write, combinational read, async clear.
// Optional MEMDATA_ADDR_ERR_EN adds addr_err / addr_err_seen outputs.
module memory_data
  import memdata_pkg::*;
#(
  parameter int unsigned DATA_W = MEMDATA_DATA_W,
  parameter int unsigned ADDR_W = MEMDATA_ADDR_W,
  parameter int unsigned DEPTH  = MEMDATA_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Rm,
  input  logic              Wm,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] RegVal,
`ifdef MEMDATA_ADDR_ERR_EN
  output logic [DATA_W-1:0] Data_out,
  output logic              addr_err,
  output logic              addr_err_seen
`else
  output logic [DATA_W-1:0] Data_out
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_rng;
  logic [IDX_W-1:0]  idx;

  // Compare with one extra bit so DEPTH == 2**ADDR_W is still representable.
  assign in_rng = ({1'b0, address} < DEPTH_L);
  assign idx    = address[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (Wm && in_rng) begin
      mem[idx] <= RegVal;
    end
  end

  always_comb begin
    Data_out = '0;
    if (Rm && in_rng) begin
      Data_out = mem[idx];
    end
  end

`ifdef MEMDATA_ADDR_ERR_EN
  assign addr_err = rst_n & (Rm | Wm) & ~in_rng;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_seen <= 1'b0;
    end else if (addr_err) begin
      addr_err_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_data.sv
// Directed scoreboard bench for memory_data (default and MEMDATA_ADDR_ERR_EN builds).
module tb_memory_data;
  import memdata_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Rm, Wm;
  logic [15:0] address;
  logic [15:0] RegVal;
  logic [15:0] Data_out;
`ifdef MEMDATA_ADDR_ERR_EN
  logic        addr_err, addr_err_seen;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string tag;
    word_t val;
  } exp_t;
  exp_t sb[$];

  word_t model [64];

  memory_data #(.DATA_W(16), .ADDR_W(16), .DEPTH(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Rm(Rm),
    .Wm(Wm),
    .address(address),
    .RegVal(RegVal),
`ifdef MEMDATA_ADDR_ERR_EN
    .Data_out(Data_out),
    .addr_err(addr_err),
    .addr_err_seen(addr_err_seen)
`else
    .Data_out(Data_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input string tag, input word_t v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, Data_out, e.val);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [15:0] a, input word_t d);
    @(negedge clk);
    address = a;
    RegVal  = d;
    Wm      = 1'b1;
    Rm      = 1'b0;
    @(posedge clk);
    #1;
    Wm = 1'b0;
    if (a < 16'd64) model[a[5:0]] = d;
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input word_t exp);
    @(negedge clk);
    address = a;
    Rm      = 1'b1;
    Wm      = 1'b0;
    expect_push(tag, exp);
    #1;
    expect_pop();
  endtask

  initial begin
    rst_n   = 1'b0;
    Rm      = 1'b1;
    Wm      = 1'b0;
    address = 16'd5;
    RegVal  = '0;
    model_clear();

    // reset state
    #2;
    expect_push("reset_read5", 16'd0);
    expect_pop();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_read("post_reset_read5", 16'd5, 16'd0);

    // basic write/read
    do_write(16'd0, 16'd15);
    do_write(16'd1, 16'd14);
    do_read("read_a0", 16'd0, 16'd15);
    do_read("read_a1", 16'd1, 16'd14);
    do_read("read_unwritten_a2", 16'd2, 16'd0);

    // fill pattern with a hole at 5
    do_write(16'd17, 16'd10);
    for (int i = 0; i < 16; i++) begin
      if (i != 5) do_write(16'(i), 16'(15 - i));
    end
    for (int i = 0; i < 18; i++) begin
      do_read($sformatf("fill_a%0d", i), 16'(i), model[i]);
    end
    do_read("fill_hole_a5_const", 16'd5, 16'd0);
    do_read("fill_a17_const", 16'd17, 16'd10);

    do_write(16'd35, 16'd37);
    do_read("read_a35", 16'd35, 16'd37);
    do_read("read_a37", 16'd37, 16'd0);

    // idle: address 0 holds 15 but Rm is low
    @(negedge clk);
    Rm = 1'b0; Wm = 1'b0; address = 16'd0;
    expect_push("idle_a0", 16'd0);
    #1;
    expect_pop();

    // top in-range word
    do_write(16'd63, 16'hBEEF);
    do_read("read_a63", 16'd63, 16'hBEEF);

    // out of range: no write, no wrap
`ifdef MEMDATA_ADDR_ERR_EN
    chk("err_seen_before_oor", {15'd0, addr_err_seen}, 16'd0);
`endif
    @(negedge clk);
    address = 16'd100; RegVal = 16'd99; Wm = 1'b1; Rm = 1'b0;
`ifdef MEMDATA_ADDR_ERR_EN
    #1;
    chk("addr_err_oor_write", {15'd0, addr_err}, 16'd1);
`endif
    @(posedge clk);
    #1;
    Wm = 1'b0;
    do_read("oor_read_a100", 16'd100, 16'd0);
`ifdef MEMDATA_ADDR_ERR_EN
    chk("addr_err_oor_read", {15'd0, addr_err}, 16'd1);
`endif
    do_read("nowrap_a36", 16'd36, 16'd0);
`ifdef MEMDATA_ADDR_ERR_EN
    chk("addr_err_inrange", {15'd0, addr_err}, 16'd0);
    chk("addr_err_seen_sticky", {15'd0, addr_err_seen}, 16'd1);
`endif
    do_write(16'd64, 16'h5555);
    do_read("nowrap_a0_after_a64", 16'd0, 16'd15);
    do_read("oor_read_a64", 16'd64, 16'd0);

    // simultaneous read/write at 3 (holds 12)
    @(negedge clk);
    address = 16'd3; RegVal = 16'd7; Rm = 1'b1; Wm = 1'b1;
    expect_push("rw_before_edge", 16'd12);
    expect_push("rw_after_edge", 16'd7);
    #1;
    expect_pop();
    @(posedge clk);
    #1;
    expect_pop();
    Wm = 1'b0;
    model[3] = 16'd7;

    // mid-sequence async reset, write in flight is lost
    @(negedge clk);
    address = 16'd7; RegVal = 16'hAAAA; Wm = 1'b1; Rm = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    expect_push("async_reset_read7", 16'd0);
    expect_pop();
`ifdef MEMDATA_ADDR_ERR_EN
    chk("err_seen_cleared", {15'd0, addr_err_seen}, 16'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    Wm = 1'b0;
    rst_n = 1'b1;
    model_clear();
    do_read("after_reset_a0", 16'd0, 16'd0);
    do_read("after_reset_a1", 16'd1, 16'd0);
    do_read("after_reset_a3", 16'd3, 16'd0);
    do_read("after_reset_a7_lost_write", 16'd7, 16'd0);
    do_read("after_reset_a35", 16'd35, 16'd0);
    do_read("after_reset_a63", 16'd63, 16'd0);

    do_write(16'd9, 16'h1234);
    do_read("post_reset_write_a9", 16'd9, 16'h1234);

    chk("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
